// File: rtl/arm_lsu.sv
// Load/store unit bridging a core request/response handshake to a single-ported,
// big-endian word memory with read-modify-write for byte and halfword stores.
module arm_lsu #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_excpt
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state;
    logic        store_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wr_word;

    logic        size_bad;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign size_bad   = (req_size == 2'b11);
    assign misaligned = ALIGN_CHECK &&
                        (((req_size == SZ_HALF) && req_addr[0]) ||
                         ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)));

    // Lane 0 is the most significant byte of the memory word.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        load_val  = 32'h0;
        merged    = mem_rdata;
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_rdata[31:24];
            2'd1:    byte_lane = mem_rdata[23:16];
            2'd2:    byte_lane = mem_rdata[15:8];
            default: byte_lane = mem_rdata[7:0];
        endcase
        half_lane = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (size_q)
            SZ_BYTE: load_val = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            SZ_HALF: load_val = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            default: load_val = mem_rdata;
        endcase
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = wdata_q[15:0];
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    // NOTE: every register here is updated with <= so all reads see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wr_word    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q    <= req_store;
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= 32'h0;
                        resp_fault <= 1'b0;
                        if (size_bad || misaligned) begin
                            resp_fault <= 1'b1;
                            state      <= RESP;
                        end else if (req_store && (req_size == SZ_WORD)) begin
                            wr_word <= req_wdata;
                            state   <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (mem_excpt) begin
                        resp_fault <= 1'b1;
                        state      <= RESP;
                    end else if (store_q) begin
                        wr_word <= merged;
                        state   <= WR;
                    end else begin
                        resp_rdata <= load_val;
                        state      <= RESP;
                    end
                end
                WR: begin
                    if (mem_excpt) resp_fault <= 1'b1;
                    state <= RESP;
                end
                default: begin
                    if (resp_ready) begin
                        resp_rdata <= 32'h0;
                        resp_fault <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

    // Decoded straight from the state register so reset drops the strobe immediately.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_write  = (state == WR);
    assign mem_addr   = ((state == RD) || (state == WR)) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = (state == WR) ? wr_word : 32'h0;

endmodule

// File: tb/tb_arm_lsu.sv
// Directed bench for arm_lsu: behavioural word memory, scoreboard of expected
// responses, latency / write-strobe / address tracking per transaction.
module tb_arm_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_excpt;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          writes;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx;
    logic [31:0] poke_data;
    logic        excpt_en = 1'b0;
    logic [31:0] excpt_addr = 32'h0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_excpt = excpt_en && (mem_addr == excpt_addr);

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_data;
        else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    arm_lsu #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .mem_excpt(mem_excpt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_idx  = addr[9:2];
        poke_data = data;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request, then track edges, write strobes and memory addresses until the response.
    task automatic run_req(input string tag, input logic store, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat,
                           input int exp_wr, input logic [31:0] exp_wdata, input int hold);
        exp_t        e;
        exp_t        got;
        int          edges;
        int          wr_cnt;
        int          acc_cnt;
        int          bad_addr;
        logic [31:0] last_wdata;
        logic [31:0] hold_rdata;
        logic        hold_fault;
        e.rdata = exp_rdata; e.fault = exp_fault; e.lat = exp_lat;
        e.writes = exp_wr; e.wdata = exp_wdata;
        sb.push_back(e);

        @(negedge clk);
        check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_store = store; req_size = size; req_signed = sgn;
        req_addr  = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = 32'h0;
        edges = 1; wr_cnt = 0; acc_cnt = 0; bad_addr = 0; last_wdata = 32'h0;
        while (!resp_valid && edges < 12) begin
            if (mem_write) begin wr_cnt++; last_wdata = mem_wdata; end
            if (mem_addr != 32'h0) begin
                acc_cnt++;
                if (mem_addr != {addr[31:2], 2'b00}) bad_addr++;
            end
            @(posedge clk);
            #1 edges++;
        end
        check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h1);
        got = sb.pop_front();
        check({tag, ".latency"}, edges, got.lat);
        check({tag, ".rdata"}, resp_rdata, got.rdata);
        check({tag, ".fault"}, {31'h0, resp_fault}, {31'h0, got.fault});
        check({tag, ".writes"}, wr_cnt, got.writes);
        check({tag, ".mem_cycles"}, acc_cnt, got.lat - 1);
        check({tag, ".bad_addr"}, bad_addr, 0);
        if (got.writes != 0) check({tag, ".mem_wdata"}, last_wdata, got.wdata);

        hold_rdata = resp_rdata;
        hold_fault = resp_fault;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 check({tag, ".hold_valid"}, {31'h0, resp_valid}, 32'h1);
            check({tag, ".hold_rdata"}, resp_rdata, hold_rdata);
            check({tag, ".hold_fault"}, {31'h0, resp_fault}, {31'h0, hold_fault});
        end
        // A request presented on the release edge must not be taken.
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h100;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        req_valid = 1'b0;
        check({tag, ".released"}, {31'h0, resp_valid}, 32'h0);
        check({tag, ".idle_after"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        check("rst.req_ready", {31'h0, req_ready}, 32'h1);
        check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst.resp_fault", {31'h0, resp_fault}, 32'h0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.mem_write", {31'h0, mem_write}, 32'h0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;

        poke(32'h100, 32'h11223344);
        poke(32'h104, 32'h80FF0000);
        poke(32'h108, 32'hCAFEF00D);
        poke(32'h10C, 32'h01020304);

        run_req("ldb_s_101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h00000022, 1'b0, 2, 0, 32'h0, 0);
        run_req("ldb_s_104", 1'b0, 2'b00, 1'b1, 32'h104, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 32'h0, 0);
        run_req("ldb_u_107", 1'b0, 2'b00, 1'b0, 32'h107, 32'h0, 32'h00000000, 1'b0, 2, 0, 32'h0, 0);
        run_req("ldh_s_104", 1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0, 32'h0, 0);
        run_req("ldh_u_104", 1'b0, 2'b01, 1'b0, 32'h104, 32'h0, 32'h000080FF, 1'b0, 2, 0, 32'h0, 0);
        run_req("ldh_s_10a", 1'b0, 2'b01, 1'b1, 32'h10A, 32'h0, 32'hFFFFF00D, 1'b0, 2, 0, 32'h0, 0);
        run_req("ldw_104", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h80FF0000, 1'b0, 2, 0, 32'h0, 0);

        run_req("stb_102", 1'b1, 2'b00, 1'b0, 32'h102, 32'h123456AA, 32'h0, 1'b0, 3, 1, 32'h1122AA44, 0);
        check("stb_102.mem", mem[8'h40], 32'h1122AA44);
        run_req("sth_106", 1'b1, 2'b01, 1'b0, 32'h106, 32'hFFFFBEEF, 32'h0, 1'b0, 3, 1, 32'h80FFBEEF, 0);
        check("sth_106.mem", mem[8'h41], 32'h80FFBEEF);
        run_req("stw_108", 1'b1, 2'b10, 1'b0, 32'h108, 32'h55667788, 32'h0, 1'b0, 2, 1, 32'h55667788, 0);
        check("stw_108.mem", mem[8'h42], 32'h55667788);

        run_req("ldw_mis_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0);
        run_req("sth_mis_105", 1'b1, 2'b01, 1'b0, 32'h105, 32'hFFFF1234, 32'h0, 1'b1, 1, 0, 32'h0, 0);
        check("sth_mis_105.mem", mem[8'h41], 32'h80FFBEEF);
        run_req("ld_size3", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0);

        excpt_en = 1'b1; excpt_addr = 32'h10C;
        run_req("stb_excpt", 1'b1, 2'b00, 1'b0, 32'h10D, 32'h000000EE, 32'h0, 1'b1, 2, 0, 32'h0, 5);
        check("stb_excpt.mem", mem[8'h43], 32'h01020304);
        run_req("ldw_excpt", 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0, 0);
        excpt_en = 1'b0;

        // Reset while the word store sits in WR: strobe must fall without a clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h108; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rstwr.in_wr", {31'h0, mem_write}, 32'h1);
        #1 rst = 1'b0;
        #1 check("rstwr.mem_write", {31'h0, mem_write}, 32'h0);
        check("rstwr.mem_addr", mem_addr, 32'h0);
        check("rstwr.req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("rstwr.no_resp", {31'h0, resp_valid}, 32'h0);
        end
        check("rstwr.mem", mem[8'h42], 32'h55667788);

        run_req("ldw_100_post", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1122AA44, 1'b0, 2, 0, 32'h0, 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arm_lsu.md
ARM_LSU -- requirements
Module: arm_lsu

Interface
REQ-001 Parameter ALIGN_CHECK, default 1, 1 = misaligned halfword/word requests fault without a memory access; 0 = low address bits are ignored for alignment.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  LSU can accept a request.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is reserved.
REQ-008 req_signed  input  1  sign-extend byte/halfword loads.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  core accepts response.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and faults.
REQ-014 resp_fault  output  1  request faulted.
REQ-015 mem_addr  output  32  word address to memory port.
REQ-016 mem_wdata  output  32  write word to memory port.
REQ-017 mem_write  output  1  memory write strobe; memory commits on the rising edge while high.
REQ-018 mem_rdata  input  32  asynchronous memory read word.
REQ-019 mem_excpt  input  1  memory reports an unmapped address.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, RD, WR, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid=1 in IDLE, and all req_* fields are latched on that edge.
REQ-022 Next state after acceptance: misaligned or size 11 -> RESP with fault; load or sub-word store -> RD; word store -> WR.
REQ-023 Misaligned means halfword with addr[0]=1 or word with addr[1:0]!=0; this check applies only when ALIGN_CHECK=1. Size 11 SHALL fault regardless of ALIGN_CHECK.
REQ-024 mem_addr SHALL be {latched_addr[31:2],2'b00} in RD and WR, and 0 otherwise.
REQ-025 mem_write SHALL be 1 only in WR, decoded directly from the state register.
REQ-026 Memory words are big-endian: byte offset 0 = bits [31:24], offset 3 = bits [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
REQ-027 In RD, the LSU SHALL capture mem_rdata on the edge leaving RD. Next state: load -> RESP; sub-word store -> WR.
REQ-028 For a sub-word store, mem_wdata in WR SHALL be the captured word with only the target lane replaced by req_wdata[7:0] or [15:0]; the other lanes are unchanged (read-modify-write).
REQ-029 For a word store, mem_wdata SHALL be req_wdata. WR lasts one cycle, then RESP.
REQ-030 Load extraction: select the lane, then zero-extend, or sign-extend when req_signed=1.
REQ-031 If mem_excpt=1 in RD or WR, next state is RESP with fault=1. A faulting RD SHALL NOT enter WR.
REQ-032 In RESP, resp_valid=1, holding resp_rdata/resp_fault stable until an edge with resp_ready=1, which returns to IDLE. No new request is accepted in that same edge.
REQ-033 Latency from accept edge to resp_valid: fault-on-decode 1 edge; load and word store 2 edges; sub-word store 3 edges.
REQ-034 A store with resp_fault=1 from decode or RD SHALL never assert mem_write.

Reset
REQ-035 While rst=0: state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_write=0, mem_addr=0, mem_wdata=0, and all latched request/data registers are 0.
REQ-036 Reset asserted mid-operation, including in WR, SHALL drop mem_write immediately (asynchronously). The pending request is discarded with no response.

Verification
REQ-037 Memory word 0x11223344 at 0x100; load byte signed addr 0x101 -> resp_rdata=0x00000022, fault=0, resp_valid 2 edges after accept.
REQ-038 Word 0x80FF0000 at 0x104; load half signed addr 0x104 -> 0xFFFF80FF; unsigned -> 0x000080FF.
REQ-039 Word 0x11223344 at 0x100; store byte 0xAA at 0x102 -> exactly one mem_write cycle with mem_wdata=0x1122AA44, resp_valid 3 edges after accept.
REQ-040 Word load at 0x102 with ALIGN_CHECK=1 -> resp_fault=1 after 1 edge, mem_addr never 0x100, mem_write never 1.
REQ-041 mem_excpt=1 during RD of a byte store -> resp_fault=1, no mem_write. Hold resp_ready=0 for 5 cycles -> resp_valid stays 1 with outputs stable.
REQ-042 Assert rst=0 while in WR -> mem_write=0 before the next edge; after release, state=IDLE, req_ready=1, no resp_valid.
